parity_sort: RTL

PARITY_SORT -- requirements
Module: parity_sort

---
 rtl/parity_sort_if.sv | 30 +++
 rtl/parity_sort.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/parity_sort_if.sv
// Bus bundle for parity_sort. With PARITY_SORT_DESC_EN defined the bundle
// carries an extra desc bit that selects descending order.
interface parity_sort_if #(
   parameter int W = 4,
   parameter int N = 10
);
   // en high marks num as a sample this cycle; no back-pressure exists,
   // the first low cycle after a load closes the batch.
   logic           en;
   logic [W-1:0]   num;
   logic           sel_odd;
   logic           valid;
   logic [N*W-1:0] out;
   logic           ovf;
   logic [2:0]     dbg_state;

`ifdef PARITY_SORT_DESC_EN
   logic           desc;

   modport master (output en, num, sel_odd, desc,
                   input  valid, out, ovf, dbg_state);
   modport slave  (input  en, num, sel_odd, desc,
                   output valid, out, ovf, dbg_state);
`else
   modport master (output en, num, sel_odd,
                   input  valid, out, ovf, dbg_state);
   modport slave  (input  en, num, sel_odd,
                   output valid, out, ovf, dbg_state);
`endif
endinterface

// File: rtl/parity_sort.sv
// Batch sorter: sorts the even- or odd-valued samples of a batch in place.
// Optional macro PARITY_SORT_DESC_EN adds a desc input for descending order.
module parity_sort #(
   parameter int W = 4,
   parameter int N = 10
) (
   input logic          clk,
   input logic          rst,
   parity_sort_if.slave bus
);
   localparam int CW = $clog2(N + 1);
   localparam int IW = $clog2(N);

   typedef enum logic [2:0] {IDLE, LOAD, SORT, MERGE, DONE} state_t;

   state_t         state, state_nx;
   logic [CW-1:0]  count, phase;
   logic [W-1:0]   slot    [N];
   logic [W-1:0]   key     [N];
   logic [N-1:0]   key_vld;
   logic           sel_q;
   logic           desc_eff;
   logic [N-1:0]   loaded, part;
   logic [W-1:0]   cmp_key [N];
   logic [N-1:0]   cmp_vld;
   logic [IW-1:0]  cmp_idx;
   logic [W-1:0]   srt_key [N];
   logic [N-1:0]   srt_vld;
   logic [N*W-1:0] mrg;
   logic [IW-1:0]  mrg_idx;
   logic [N*W-1:0] out_q;
   logic           valid_q, ovf_q;

`ifdef PARITY_SORT_DESC_EN
   logic desc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         desc_q <= 1'b0;
      end else if (bus.en && (state == IDLE || state == DONE)) begin
         desc_q <= bus.desc;
      end
   end

   assign desc_eff = desc_q;
`else
   assign desc_eff = 1'b0;
`endif

   // Invalid padding always sinks to the end of the key list.
   function automatic logic out_of_order(input logic va, input logic vb,
                                         input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic dsc);
      if (!va) return vb;
      if (!vb) return 1'b0;
      return dsc ? (a < b) : (a > b);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.en) state_nx = LOAD;
         LOAD:    if (!bus.en) state_nx = SORT;
         SORT:    if (phase == CW'(N - 1)) state_nx = MERGE;
         MERGE:   state_nx = DONE;
         DONE:    if (bus.en) state_nx = LOAD;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      loaded = '0;
      part   = '0;
      for (int i = 0; i < N; i++) begin
         loaded[i] = CW'(i) < count;
         part[i]   = loaded[i] && (slot[i][0] == sel_q);
      end
   end

   // Pack participating values to the front of the key list.
   always_comb begin
      cmp_idx = '0;
      cmp_vld = '0;
      for (int i = 0; i < N; i++) cmp_key[i] = '0;
      for (int i = 0; i < N; i++) begin
         if (part[i]) begin
            cmp_key[cmp_idx] = slot[i];
            cmp_vld[cmp_idx] = 1'b1;
            cmp_idx          = cmp_idx + IW'(1);
         end
      end
   end

   always_comb begin
      srt_key = key;
      srt_vld = key_vld;
      for (int i = 0; i < N - 1; i++) begin
         if (((i % 2) == 1) == phase[0]) begin
            if (out_of_order(key_vld[i], key_vld[i+1], key[i], key[i+1], desc_eff)) begin
               srt_key[i]   = key[i+1];
               srt_key[i+1] = key[i];
               srt_vld[i]   = key_vld[i+1];
               srt_vld[i+1] = key_vld[i];
            end
         end
      end
   end

   always_comb begin
      mrg     = '0;
      mrg_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (part[i]) begin
            mrg[(N-i)*W-1 -: W] = key[mrg_idx];
            mrg_idx             = mrg_idx + IW'(1);
         end else if (loaded[i]) begin
            mrg[(N-i)*W-1 -: W] = slot[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         phase   <= '0;
         sel_q   <= 1'b0;
         key_vld <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < N; i++) begin
            slot[i] <= '0;
            key[i]  <= '0;
         end
      end else begin
         case (state)
            IDLE, LOAD: begin
               if (bus.en) begin
                  if (count < CW'(N)) begin
                     slot[count[IW-1:0]] <= bus.num;
                     count               <= count + CW'(1);
                     if (state == IDLE) sel_q <= bus.sel_odd;
                  end else begin
                     ovf_q <= 1'b1;
                  end
               end else if (state == LOAD) begin
                  key     <= cmp_key;
                  key_vld <= cmp_vld;
                  phase   <= '0;
               end
            end
            SORT: begin
               key     <= srt_key;
               key_vld <= srt_vld;
               phase   <= phase + CW'(1);
            end
            MERGE: begin
               out_q   <= mrg;
               valid_q <= 1'b1;
            end
            DONE: begin
               // A new batch starts; out keeps the previous result until MERGE.
               if (bus.en) begin
                  for (int i = 0; i < N; i++) slot[i] <= '0;
                  slot[0] <= bus.num;
                  count   <= CW'(1);
                  sel_q   <= bus.sel_odd;
                  valid_q <= 1'b0;
                  ovf_q   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.valid     = valid_q;
   assign bus.out       = out_q;
   assign bus.ovf       = ovf_q;
   assign bus.dbg_state = state;
endmodule
